// File: rtl/keypad_pkg.sv
// Shared types, defaults and key-code table for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    WAIT_DEB = 2'd1,
    WAIT_REL = 2'd2,
    RECOVER  = 2'd3
  } kp_state_e;

  localparam int SCAN_DIV_DEF    = 16;
  localparam int DEB_TIMEOUT_DEF = 64;
  localparam int REL_CYC_DEF     = 8;

  // Indexed by {row, col}; entry 0 (row0/col0) is the rightmost element.
  localparam logic [15:0][3:0] KEY_LUT = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Lowest-index active-low column wins when several keys share a row.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small FIFO with a registered head word; full pushes are dropped and flagged sticky.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic             pop, full, wr_en;

  always_comb begin
    pop      = valid_q & pop_ready;
    full     = (cnt_q == FULL_CNT);
    wr_en    = push & (~full | pop);
    rd_nxt   = rd_ptr_q + 1'b1;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    ovf_d    = ovf_q | (push & full & ~pop);
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_nxt;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Head register tracks whichever entry will be at the read pointer next.
    if (pop) begin
      if (cnt_q > ONE_CNT) data_d = mem_q[rd_nxt];
      else if (wr_en)      data_d = push_data;
    end else if (cnt_q == '0 && wr_en) begin
      data_d = push_data;
    end
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 keypad scanner: walks rows, waits for the external debouncer, queues key codes.
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV    = SCAN_DIV_DEF,
  parameter int DEB_TIMEOUT = DEB_TIMEOUT_DEF,
  parameter int REL_CYC     = REL_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  input  logic       key_stable,
  output logic [3:0] row,
  output logic       key_det,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);
  localparam int MAX_CNT = (SCAN_DIV > DEB_TIMEOUT)
                           ? ((SCAN_DIV > REL_CYC) ? SCAN_DIV : REL_CYC)
                           : ((DEB_TIMEOUT > REL_CYC) ? DEB_TIMEOUT : REL_CYC);
  localparam int CNT_W = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_CYC - 1);
  localparam logic [CNT_W-1:0] QUAL_CNT  = CNT_W'(3);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [3:0]       col_s1_q, col_s2_q;
  logic             ks_prev_q;
  kp_state_e        state_q, state_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press, ks_rise, push;
  logic [3:0]       push_code;

  assign press     = (col_s2_q != 4'hF);
  assign ks_rise   = key_stable & ~ks_prev_q;
  assign push_code = KEY_LUT[{row_idx_q, low_col(col_s2_q)}];
  assign row       = ~(4'b0001 << row_idx_q);

  // One shared counter: row dwell in SCAN, timeout in WAIT_DEB, idle run in WAIT_REL.
  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    cnt_d     = sat_inc(cnt_q);
    push      = 1'b0;
    key_det   = 1'b0;
    case (state_q)
      SCAN: begin
        if (press && cnt_q >= QUAL_CNT) begin
          state_d = WAIT_DEB;
          cnt_d   = '0;
        end else if (cnt_q == SCAN_LAST) begin
          row_idx_d = row_idx_q + 2'd1;
          cnt_d     = '0;
        end
      end
      WAIT_DEB: begin
        key_det = press;
        if (ks_rise && press) begin
          push    = 1'b1;
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = SCAN;
          row_idx_d = row_idx_q + 2'd1;
          cnt_d     = '0;
        end
      end
      WAIT_REL: begin
        if (press) begin
          cnt_d = '0;
        end else if (cnt_q == REL_LAST) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end
      end
      RECOVER: begin
        state_d   = SCAN;
        row_idx_d = row_idx_q + 2'd1;
        cnt_d     = '0;
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1_q  <= 4'hF;
      col_s2_q  <= 4'hF;
      ks_prev_q <= 1'b0;
      state_q   <= SCAN;
      row_idx_q <= 2'd0;
      cnt_q     <= '0;
    end else begin
      col_s1_q  <= col;
      col_s2_q  <= col_s1_q;
      ks_prev_q <= key_stable;
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
    end
  end

  key_fifo #(
    .DEPTH(4),
    .WIDTH(4)
  ) u_key_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_code),
    .pop_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Directed bench for module_keypad_scanner with a behavioural keypad/queue model.
module tb_module_keypad_scanner;
  localparam int SD = 16, DT = 64, RC = 8;
  localparam int P_SCAN = 0, P_DEB = 1, P_REL = 2, P_REC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col = 4'hF;
  logic       key_stable = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] row, out_data;
  logic       key_det, out_valid, overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  module_keypad_scanner #(.SCAN_DIV(SD), .DEB_TIMEOUT(DT), .REL_CYC(RC)) dut (
    .clk(clk), .rst(rst), .col(col), .key_stable(key_stable), .row(row),
    .key_det(key_det), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow)
  );

  // ---------------- behavioural model ----------------
  int         m_phase = P_SCAN;
  int         m_row = 0;
  int         m_age = 0;
  int         m_idle = 0;
  bit         m_ksp = 1'b0;
  bit         m_ovf = 1'b0;
  logic [3:0] m_hist[$] = '{4'hF, 4'hF};
  logic [3:0] m_q[$];

  function automatic logic [3:0] key_of(input int r, input int c);
    if (c == 3) return 4'(10 + r);
    if (r == 3) return (c == 0) ? 4'hE : ((c == 1) ? 4'h0 : 4'hF);
    return 4'(r * 3 + c + 1);
  endfunction

  function automatic int first_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 3;
  endfunction

  task automatic model_step();
    bit pressed, rise, pop, push, was_full;
    logic [3:0] code;
    pressed = (m_hist[1] != 4'hF);
    rise    = key_stable && !m_ksp;
    pop     = (m_q.size() != 0) && out_ready;
    push    = 1'b0;
    code    = 4'h0;
    m_idle  = pressed ? 0 : m_idle + 1;
    case (m_phase)
      P_SCAN:
        if (pressed && m_age >= 3) begin m_phase = P_DEB; m_age = 0; end
        else if (m_age + 1 == SD) begin m_row = (m_row + 1) % 4; m_age = 0; end
        else m_age++;
      P_DEB:
        if (rise && pressed) begin
          push = 1'b1; code = key_of(m_row, first_low(m_hist[1]));
          m_phase = P_REL; m_age = 0;
        end else if (m_age + 1 == DT) begin
          m_phase = P_SCAN; m_row = (m_row + 1) % 4; m_age = 0;
        end else m_age++;
      P_REL:
        if (m_idle >= RC) begin m_phase = P_REC; m_age = 0; end
      default: begin m_phase = P_SCAN; m_row = (m_row + 1) % 4; m_age = 0; end
    endcase
    was_full = (m_q.size() == 4);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!was_full || pop) m_q.push_back(code);
      else m_ovf = 1'b1;
    end
    m_ksp = key_stable;
    m_hist.push_front(col);
    void'(m_hist.pop_back());
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_phase = P_SCAN; m_row = 0; m_age = 0; m_idle = 0;
      m_ksp = 1'b0; m_ovf = 1'b0; m_q.delete();
      m_hist.delete(); m_hist.push_back(4'hF); m_hist.push_back(4'hF);
    end else begin
      model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [3:0] er;
    er = ~(4'b0001 << m_row);
    check("row", row, er);
    check("key_det", key_det, (m_phase == P_DEB) && (m_hist[1] != 4'hF));
    check("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("out_data", out_data, m_q[0]);
    check("overflow", overflow, m_ovf);
  endtask

  initial forever begin
    @(negedge clk);
    compare_outputs();
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_row_enter(input int idx);
    logic [3:0] tgt, prev;
    bit ok;
    int n;
    tgt = ~(4'b0001 << idx);
    prev = row; n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk); n++;
      ok = (row == tgt) && (prev != tgt);
      prev = row;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL row_enter: got row %b expected entry into %b within 200 cycles", row, tgt);
    end
  endtask

  task automatic wait_det(input logic lvl, input int bound, input string name);
    int n;
    n = 0;
    while (key_det !== lvl && n < bound) begin @(negedge clk); n++; end
    check(name, key_det, lvl);
  endtask

  task automatic press(input int idx, input logic [3:0] cp, input bit pop_same, input bit bounce);
    logic [3:0] tgt;
    tgt = ~(4'b0001 << idx);
    wait_row_enter(idx);
    col = cp;
    wait_det(1'b1, 20, "press_det");
    key_stable = 1'b1;
    if (pop_same) out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("det_drop_rel", key_det, 1'b0);
    repeat (2) @(negedge clk);
    key_stable = 1'b0;
    if (bounce) begin
      repeat (4) begin
        col = 4'hF;  repeat (5) @(negedge clk);
        col = 4'hE;  repeat (5) @(negedge clk);
        check("bounce_row_frozen", row, tgt);
      end
    end
    col = 4'hF;
    repeat (14) @(negedge clk);
  endtask

  logic [3:0] exp_first [4] = '{4'h1, 4'h6, 4'hE, 4'hD};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_row", row, 4'b1110);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 4'h0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_det", key_det, 1'b0);
    rst = 1'b1;

    // Idle scan: 16 cycles per row
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i == 8)  check("scan_r0", row, 4'b1110);
      if (i == 24) check("scan_r1", row, 4'b1101);
      if (i == 40) check("scan_r2", row, 4'b1011);
      if (i == 56) check("scan_r3", row, 4'b0111);
    end
    check("scan_valid", out_valid, 1'b0);

    // Key '8' with bouncing release
    press(2, 4'b1101, 1'b0, 1'b1);
    check("k8_valid", out_valid, 1'b1);
    check("k8_data", out_data, 4'h8);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("k8_single_push", out_valid, 1'b0);

    // Debounce timeout
    wait_row_enter(1);
    col = 4'b0111;
    wait_det(1'b1, 20, "to_det");
    wait_det(1'b0, 100, "to_expire");
    check("to_row_adv", row, 4'b1011);
    col = 4'hF;
    check("to_nopush", out_valid, 1'b0);
    repeat (10) @(negedge clk);

    // Five presses with no consumer
    press(0, 4'b1110, 1'b0, 1'b0);
    press(1, 4'b1011, 1'b0, 1'b0);
    press(3, 4'b1110, 1'b0, 1'b0);
    press(3, 4'b0111, 1'b0, 1'b0);
    check("pre_ovf", overflow, 1'b0);
    press(2, 4'b1011, 1'b0, 1'b0);
    check("ovf_set", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", out_valid, 1'b1);
      check("drain_data", out_data, exp_first[k]);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("drain_empty", out_valid, 1'b0);

    // Refill, then push and pop together while full
    press(0, 4'b0111, 1'b0, 1'b0);
    press(1, 4'b1110, 1'b0, 1'b0);
    press(2, 4'b1110, 1'b0, 1'b0);
    press(3, 4'b1101, 1'b0, 1'b0);
    press(0, 4'b1101, 1'b1, 1'b0);
    check("fullpp_data", out_data, 4'h4);
    check("ovf_sticky", overflow, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("three_left", out_data, 4'h7);

    // Asynchronous reset with three codes queued
    #3 rst = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_ovf", overflow, 1'b0);
    check("arst_data", out_data, 4'h0);
    check("arst_row", row, 4'b1110);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_ovf", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/module_keypad_scanner.md
MODULE_KEYPAD_SCANNER -- requirements
Module: module_keypad_scanner

Parameters
REQ-001 SCAN_DIV, 16, number of clk cycles each row stays driven while scanning (must be at least 4).
REQ-002 DEB_TIMEOUT, 64, number of clk cycles to wait for key_stable before abandoning a detected press.
REQ-003 REL_CYC, 8, number of consecutive idle-column cycles that count as a key release.

Interface
REQ-004 clk  in  1  single clock; all logic is on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 col  in  4  keypad column lines; active-low; asynchronous to clk.
REQ-007 key_stable  in  1  debounced, stable-press level from the downstream debouncer.
REQ-008 row  out  4  keypad row drive; one-hot-low.
REQ-009 key_det  out  1  raw press indication; feeds the debouncer button input.
REQ-010 out_data  out  4  encoded key code at the head of the queue.
REQ-011 out_valid  out  1  queue is not empty.
REQ-012 out_ready  in  1  consumer accepts out_data.
REQ-013 overflow  out  1  sticky flag: a key press was dropped because the queue was full.

Function
REQ-014 col SHALL pass through a 2-FF synchronizer; "press" means the synchronized value colS != 4'hF.
REQ-015 The FSM SHALL have exactly four states: SCAN, WAIT_DEB, WAIT_REL, RECOVER.
REQ-016 SCAN: row steps through 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step every SCAN_DIV cycles.
- On press, row freezes and the next state is WAIT_DEB.
- Press detection is qualified only after 3 cycles in the current row, to cover synchronizer latency.
REQ-017 key_det SHALL equal 1 in WAIT_DEB while press holds, and 0 in all other states.
REQ-018 WAIT_DEB, on a rising edge of key_stable while pressed:
- latch code from the frozen row and colS (lowest-index low column wins);
- push the code into the queue;
- go to WAIT_REL.
REQ-019 WAIT_DEB: if DEB_TIMEOUT cycles elapse without that edge, go to SCAN with row advanced one step; nothing is pushed.
REQ-020 WAIT_REL: go to RECOVER after REL_CYC consecutive non-press cycles; any press cycle restarts the count.
REQ-021 RECOVER: hold one cycle, then go to SCAN with row advanced one step.
REQ-022 Key code map, row0..row3 by col0..col3:
- row0: 1 2 3 A
- row1: 4 5 6 B
- row2: 7 8 9 C
- row3: E(*) 0 F(#) D
REQ-023 The queue SHALL be a 4-entry FIFO. Pop occurs when out_valid & out_ready. out_data is registered and shows the head entry.
REQ-024 Push into an empty FIFO: out_valid rises the following cycle; there is no bypass path.
REQ-025 Push into a full FIFO with no pop in the same cycle: the code is dropped and overflow is set to 1 until reset.
REQ-026 Push and pop in the same cycle while full: both occur and occupancy stays at 4.
REQ-027 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 Counters SHALL saturate and never wrap. The FIFO read and write pointers are 2 bits and wrap 3 -> 0.

Reset
REQ-029 While rst=0, all state SHALL clear asynchronously to these values:
- state=SCAN, row=1110, key_det=0;
- out_valid=0, out_data=0, overflow=0;
- FIFO empty, all counters 0.
REQ-030 Reset asserted mid-operation SHALL discard any queued codes and any in-progress capture. Deassertion takes effect synchronously on the next posedge.

Structure
REQ-031 Package keypad_pkg SHALL hold:
- the state enum;
- the 16-entry key-code lookup table;
- the default values of SCAN_DIV, DEB_TIMEOUT and REL_CYC.
REQ-032 The queue SHALL be a separate sub-module, key_fifo, with DEPTH=4 and WIDTH=4.

Verification
REQ-033 After reset: hold col=1111 and step 64 cycles -> row visits 1110, 1101, 1011, 0111 in order at 16-cycle intervals; out_valid=0.
REQ-034 During row=1011, drive col=1101, then pulse key_stable -> out_valid=1, out_data=4'h8, key_det drops in WAIT_REL.
REQ-035 Drive a press with key_stable held at 0 for 64 cycles -> no push, and row advances on return to SCAN.
REQ-036 Make 5 presses with out_ready=0 -> the FIFO holds the first 4 codes, overflow=1, and draining returns them in order.
REQ-037 During release, bounce col between 1111 and 1110 every 5 cycles -> the FSM stays in WAIT_REL and no second push occurs.
REQ-038 Assert rst=0 with 3 entries queued -> out_valid=0 immediately; after release the FIFO is empty and overflow=0.
